// File: rtl/mult_pkg.sv
// Shared definitions for the execute-stage multiplier and the decoder feeding it.
package mult_pkg;

  localparam logic [3:0] MODE_MUL   = 4'd1;
  localparam logic [3:0] MODE_UMULL = 4'd2;
  localparam logic [3:0] MODE_SMULL = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic mode_valid(input logic [3:0] m);
    return (m == MODE_MUL) || (m == MODE_UMULL) || (m == MODE_SMULL);
  endfunction

endpackage

// File: rtl/mult_signfix.sv
// Conditional two's-complement negate; serves as abs() at operand load and as
// the final product negate.
module mult_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? ((~val) + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier (MUL/UMULL/SMULL) with sign-magnitude handling.
// Optional MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is 0.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mode,
  input  logic             s_on,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flags_we,
  output logic             flag_n,
  output logic             flag_z
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         mode_q, mode_d;
  logic               s_on_q, s_on_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;

  logic               is_smull;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   step;
  logic [2*WIDTH:0]   acc_run;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               last;
  logic               early;
  logic               is_mul;

  assign is_smull = (mode == MODE_SMULL);
  assign is_mul   = (mode_q == MODE_MUL);

  mult_signfix #(.W(WIDTH)) u_abs_a (
    .val (op_a),
    .neg (is_smull & op_a[WIDTH-1]),
    .res (abs_a)
  );

  mult_signfix #(.W(WIDTH)) u_abs_b (
    .val (op_b),
    .neg (is_smull & op_b[WIDTH-1]),
    .res (abs_b)
  );

  mult_signfix #(.W(2*WIDTH)) u_neg_p (
    .val (acc_q[2*WIDTH-1:0]),
    .neg (neg_q),
    .res (prod_fix)
  );

  // Add into the upper half, then shift the whole accumulator right by one.
  assign sum        = acc_q[2*WIDTH:WIDTH] + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign step       = {sum, acc_q[WIDTH-1:0]} >> 1;
  assign mplier_nxt = mplier_q >> 1;
  assign last       = (cnt_q == CNT_W'(WIDTH-1));

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] rem;
  assign rem     = CNT_W'(WIDTH-1) - cnt_q;
  assign early   = (mplier_nxt == '0);
  // Skipped iterations would only shift, so fold them into one barrel shift.
  assign acc_run = early ? (step >> rem) : step;
`else
  assign early   = 1'b0;
  assign acc_run = step;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    s_on_d   = s_on_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    n_d      = n_q;
    z_d      = z_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (start && mode_valid(mode)) begin
          mode_d   = mode;
          s_on_d   = s_on;
          neg_d    = is_smull & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          mcand_d  = abs_a;
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_run;
        mplier_d = mplier_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (last || early) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        lo_d    = prod_fix[WIDTH-1:0];
        hi_d    = is_mul ? '0 : prod_fix[2*WIDTH-1:WIDTH];
        done_d  = 1'b1;
        we_d    = s_on_q;
        if (s_on_q) begin
          n_d = is_mul ? prod_fix[WIDTH-1] : prod_fix[2*WIDTH-1];
          z_d = is_mul ? (prod_fix[WIDTH-1:0] == '0) : (prod_fix == '0);
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= '0;
      s_on_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      s_on_q   <= s_on_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      n_q      <= n_d;
      z_q      <= z_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign flags_we  = we_q;
  assign flag_n    = n_q;
  assign flag_z    = z_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: results, flags, latency, busy handshake, reset abort.
module tb_mult_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  mode;
  logic        s_on;
  logic [31:0] op_a, op_b;
  logic        busy, done, flags_we, flag_n, flag_z;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  mult_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .s_on(s_on),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lat: edges after acceptance until done seen; bedges: edges from acceptance to busy fall, inclusive.
  task automatic run_op(input logic [3:0] m, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bedges, output logic we);
    mode = m; s_on = s; op_a = a; op_b = b; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    we = 1'b0;
    while (!done && lat < 100) begin
      tick;
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL op_timeout got no done want done within 100 cycles");
    end
    we = flags_we;
    bedges = lat + 1;
    while (busy && bedges < 200) begin
      tick;
      bedges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 4'd0; s_on = 1'b0; op_a = '0; op_b = '0;
    tick; tick;
    checks++;
    if ({busy, done, flags_we, flag_n, flag_z} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, flags_we, flag_n, flag_z});
    end
    checks++;
    if ({result_hi, result_lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", {result_hi, result_lo});
    end
    rst_n = 1'b1;
    tick;
    // invalid mode must be ignored
    mode = 4'd7; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_mode_ignored got busy=%b want 0", busy);
    end
  endtask

  task automatic test_mul;
    int lat, be; logic we;
    run_op(4'd1, 1'b1, 32'd7, 32'd6, lat, be, we);
    checks++;
    if (result_lo !== 32'd42 || result_hi !== 32'd0) begin
      errors++;
      $display("FAIL mul_result got %h_%h want 00000000_0000002a", result_hi, result_lo);
    end
    checks++;
    if (we !== 1'b1 || flag_n !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL mul_flags got we=%b n=%b z=%b want 1 0 0", we, flag_n, flag_z);
    end
`ifndef MULT_EARLY_TERM_EN
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL mul_latency got %0d want 33", lat);
    end
    checks++;
    if (be != 35) begin
      errors++;
      $display("FAIL mul_busy_edges got %0d want 35", be);
    end
`endif
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_after_done got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_smull;
    int lat, be; logic we;
    run_op(4'd3, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, be, we);
    checks++;
    if (result_hi !== 32'h4000_0000 || result_lo !== 32'h0) begin
      errors++;
      $display("FAIL smull_min got %h_%h want 40000000_00000000", result_hi, result_lo);
    end
    checks++;
    if (flag_n !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL smull_min_flags got n=%b z=%b want 0 0", flag_n, flag_z);
    end
    run_op(4'd3, 1'b1, 32'hFFFF_FFFE, 32'd3, lat, be, we);
    checks++;
    if (result_hi !== 32'hFFFF_FFFF || result_lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL smull_neg got %h_%h want ffffffff_fffffffa", result_hi, result_lo);
    end
    checks++;
    if (we !== 1'b1 || flag_n !== 1'b1 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL smull_neg_flags got we=%b n=%b z=%b want 1 1 0", we, flag_n, flag_z);
    end
  endtask

  task automatic test_umull;
    int lat, be; logic we;
    run_op(4'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, be, we);
    checks++;
    if (result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL umull_max got %h_%h want fffffffe_00000001", result_hi, result_lo);
    end
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL umull_we got %b want 0", we);
    end
    // flags must hold the previous SMULL values
    checks++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL umull_flag_hold got n=%b z=%b want 1 0", flag_n, flag_z);
    end
  endtask

  task automatic test_mul_trunc;
    int lat, be; logic we;
    run_op(4'd1, 1'b1, 32'h0001_0000, 32'h0001_0000, lat, be, we);
    checks++;
    if (result_lo !== 32'd0 || result_hi !== 32'd0) begin
      errors++;
      $display("FAIL trunc_result got %h_%h want 0_0", result_hi, result_lo);
    end
    checks++;
    if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
      errors++;
      $display("FAIL trunc_flags got n=%b z=%b want 0 1", flag_n, flag_z);
    end
  endtask

  task automatic test_back_to_back;
    int n, dones;
    mode = 4'd1; s_on = 1'b0; op_a = 32'd5; op_b = 32'd3; start = 1'b1;
    tick;
    op_a = 32'd9; op_b = 32'd9;
    n = 0; dones = 0;
    while (!done && n < 100) begin
      tick;
      n++;
    end
    if (done) dones++;
    checks++;
    if (dones != 1 || result_lo !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first got dones=%0d lo=%0d want 1 15", dones, result_lo);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", busy);
    end
    n = 0;
    while (!done && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (done !== 1'b1 || result_lo !== 32'd81) begin
      errors++;
      $display("FAIL b2b_second got done=%b lo=%0d want 1 81", done, result_lo);
    end
    tick; tick;
  endtask

  task automatic test_early;
    int lat, be; logic we;
    run_op(4'd2, 1'b0, 32'd5, 32'd1, lat, be, we);
    checks++;
    if (result_lo !== 32'd5 || result_hi !== 32'd0) begin
      errors++;
      $display("FAIL early_result got %h_%h want 0_5", result_hi, result_lo);
    end
    checks++;
`ifdef MULT_EARLY_TERM_EN
    if (lat != 2) begin
      errors++;
      $display("FAIL early_latency got %0d want 2", lat);
    end
`else
    if (lat != 33) begin
      errors++;
      $display("FAIL early_latency got %0d want 33", lat);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int dones;
    mode = 4'd2; s_on = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, flags_we, flag_n, flag_z, result_hi, result_lo} !== 69'd0) begin
      errors++;
      $display("FAIL reset_mid_async got busy=%b lo=%h hi=%h want all 0", busy, result_lo, result_hi);
    end
    tick; tick;
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      tick;
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort got dones=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_smull;
    test_umull;
    test_mul_trunc;
    test_back_to_back;
    test_early;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle execute-stage multiplier, directly downstream of the instruction decoder.
- Consumes the decoder's mult_hot, mode and S_on outputs, plus register-file read data for Rm and Rs.
- Produces a 32- or 64-bit product for the register write-back path, with optional N/Z flag update.
- Radix-2 shift-add core; signed multiply is handled by magnitude multiply plus final negate.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; decoder mult_hot qualified by instruction-valid
- mode  input  4  MODE_MUL=4'd1, MODE_UMULL=4'd2, MODE_SMULL=4'd3
- s_on  input  1  update flags on completion
- op_a  input  WIDTH  Rm value (multiplicand)
- op_b  input  WIDTH  Rs value (multiplier)
- busy  output  1  operation in progress; start is ignored while high
- done  output  1  one-cycle pulse; results valid
- result_lo  output  WIDTH  product[WIDTH-1:0]
- result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH]; 0 for MUL
- flags_we  output  1  pulses with done when latched s_on=1
- flag_n  output  1  negative flag
- flag_z  output  1  zero flag

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counter 0. Reset asserted mid-operation aborts immediately, with no done pulse.
- States: IDLE, RUN, SIGN, DONE.
- IDLE:
  - Start with mode in {1,2,3}: latch mode and s_on, load the operands, then go to RUN with count=0 and busy=1.
  - Start with any other mode: ignored; stay in IDLE.
- Operand load:
  - SMULL: load |op_a| and |op_b|, and latch neg = op_a[31]^op_b[31].
  - Other modes: load raw values with neg=0.
  - abs(0x80000000) = 0x80000000, interpreted as unsigned.
- RUN:
  - Each cycle: if multiplier LSB is 1, add multiplicand into the upper half of the 2*WIDTH+1-bit accumulator.
  - Then shift the accumulator and multiplier right by one; count increments.
  - After WIDTH iterations (count==WIDTH-1 on the last edge), go to SIGN.
- SIGN: if neg, product = two's complement of product (64-bit). Go to DONE.
- DONE:
  - result_lo/result_hi registered; done=1 and flags_we=s_on_latched for exactly this cycle.
  - Next edge returns to IDLE and busy drops.
- Latency: start sampled at edge E0; done is high in the cycle after edge E33 (WIDTH+1 edges after acceptance). busy is high from E0 through E34.
- A new start in the cycle after done (IDLE) is accepted.
- A start while busy=1 is ignored; there is no queueing.
- Flags:
  - flag_n = result bit 31 for MUL, bit 63 for long forms.
  - flag_z = (low 32 bits == 0) for MUL, (64 bits == 0) for long forms.
  - Flags update only when flags_we=1 and hold otherwise.
- Results and flags hold until the next completion.
- MUL: result_hi is forced to 0; result_lo is product[31:0], identical for signed and unsigned.
- Wrap-around: MUL truncates silently; no overflow or carry output.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, if the remaining (already-shifted) multiplier is 0, skip to SIGN on that edge, applying the pending shift in a single step so alignment is preserved. The accumulator right-aligns by the remaining count via a barrel shift. Minimum latency is 2 edges to SIGN when op_b==0. done timing is data-dependent; the handshake is unchanged.
- Undefined: fixed WIDTH iterations.

Decomposition:
- Shared package mult_pkg:
  - MODE_MUL/MODE_UMULL/MODE_SMULL constants, matching decoder mode encodings; the decoder uses the same package.
  - FSM state encoding (IDLE=0, RUN=1, SIGN=2, DONE=3).
- One natural sub-module: mult_signfix, a combinational abs/negate helper (WIDTH and 2*WIDTH variants via parameter). It is used at load and in SIGN.
- The rest stays flat.

Test Plan:
- MUL, op_a=7, op_b=6, s_on=1:
  - Expect result_lo=42, result_hi=0, flag_n=0, flag_z=0.
  - Expect done exactly 33 cycles after start is sampled (without MULT_EARLY_TERM_EN), and busy high 35 cycles.
- UMULL, 0xFFFFFFFF×0xFFFFFFFF: result_hi=0xFFFFFFFE, result_lo=0x00000001, flags_we=0 with s_on=0.
- SMULL, op_a=0xFFFFFFFE (-2), op_b=3, s_on=1: result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, flag_n=1, flag_z=0. Also SMULL 0x80000000×0x80000000: result_hi=0x40000000, result_lo=0.
- MUL, 0x10000×0x10000, s_on=1: result_lo=0, flag_z=1, flag_n=0 (truncation).
- Start held high while busy, with different operands: second request ignored; exactly one done, carrying the first result. Start in IDLE the cycle after done: accepted.
- Reset asserted at cycle 10 of RUN: all outputs 0 asynchronously, no done, IDLE.
- With MULT_EARLY_TERM_EN, UMULL 5×1: correct result 5 and done well before 33 cycles.
